// File: rtl/mem_burst_arbiter_pkg.sv
// Shared encodings for mem_burst_arbiter: FSM states, slot/direction encoding, burst length width.
package mem_arb_pkg;

    localparam int LEN_BITS = 10;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_RD = 2'd1,
        ST_BUSY_WR = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // Slot k = 2*ch + dir, so a channel's read slot always sits just below its write slot.
    function automatic int slot_of(input int ch, input logic dir);
        return 2 * ch + int'(dir);
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, searching upward with wrap.
// The pointer moves to one past the winner only when the caller accepts the grant.
module rr_arbiter #(
    parameter  int REQS  = 8,
    localparam int IDX_W = $clog2(REQS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [REQS-1:0]  req_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               idx;

    // Walk from the farthest candidate back to the pointer so the last hit is the nearest one.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = REQS - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= REQS) begin
                idx = idx - REQS;
            end
            if (req_i[idx]) begin
                grant_o = IDX_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (grant_o == IDX_W'(REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_o + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one burst-engine port among NUM_CH DMA channels (one rd and one wr slot each), one burst at a time.
// Build option ARB_CH0_PRIORITY_EN: slots 0/1 (display channel) pre-empt round-robin arbitration.
//
//  state      | meaning
//  IDLE       | arbitrating; latch winner slot, len and addr on a grant
//  BUSY_RD    | read burst in flight for grant_slot
//  BUSY_WR    | write burst in flight for grant_slot
//  RELEASE    | one dead cycle after finish so the owner can drop or reissue its req
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24
) (
    input  logic                            mem_clk,
    input  logic                            rst_n,
    input  logic                            mem_init_done,
    input  logic [NUM_CH-1:0]               ch_rd_req,
    input  logic [NUM_CH*LEN_BITS-1:0]      ch_rd_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]     ch_rd_addr,
    input  logic [NUM_CH-1:0]               ch_wr_req,
    input  logic [NUM_CH*LEN_BITS-1:0]      ch_wr_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]     ch_wr_addr,
    input  logic [NUM_CH*MEM_DATA_BITS-1:0] ch_wr_data,
    output logic [MEM_DATA_BITS-1:0]        ch_rd_data,
    output logic [NUM_CH-1:0]               ch_rd_data_valid,
    output logic [NUM_CH-1:0]               ch_wr_data_req,
    output logic [NUM_CH-1:0]               ch_rd_finish,
    output logic [NUM_CH-1:0]               ch_wr_finish,
    output logic                            rd_burst_req,
    output logic                            wr_burst_req,
    output logic [LEN_BITS-1:0]             rd_burst_len,
    output logic [LEN_BITS-1:0]             wr_burst_len,
    output logic [ADDR_BITS-1:0]            rd_burst_addr,
    output logic [ADDR_BITS-1:0]            wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
    input  logic                            rd_burst_data_valid,
    input  logic                            wr_burst_data_req,
    input  logic                            rd_burst_finish,
    input  logic                            wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]        rd_burst_data
);

    localparam int SLOTS  = 2 * NUM_CH;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CH_W   = SLOT_W - 1;

    logic [LEN_BITS-1:0]      rd_len_a  [NUM_CH];
    logic [LEN_BITS-1:0]      wr_len_a  [NUM_CH];
    logic [ADDR_BITS-1:0]     rd_addr_a [NUM_CH];
    logic [ADDR_BITS-1:0]     wr_addr_a [NUM_CH];
    logic [MEM_DATA_BITS-1:0] wr_data_a [NUM_CH];
    logic [SLOTS-1:0]         eligible;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign rd_len_a[c]  = ch_rd_len[c*LEN_BITS +: LEN_BITS];
        assign wr_len_a[c]  = ch_wr_len[c*LEN_BITS +: LEN_BITS];
        assign rd_addr_a[c] = ch_rd_addr[c*ADDR_BITS +: ADDR_BITS];
        assign wr_addr_a[c] = ch_wr_addr[c*ADDR_BITS +: ADDR_BITS];
        assign wr_data_a[c] = ch_wr_data[c*MEM_DATA_BITS +: MEM_DATA_BITS];
        // Zero-length requests are invisible to arbitration, so they never get a finish.
        assign eligible[slot_of(c, DIR_RD)] = ch_rd_req[c] && (rd_len_a[c] != '0);
        assign eligible[slot_of(c, DIR_WR)] = ch_wr_req[c] && (wr_len_a[c] != '0);
    end

    arb_state_e           state_q, state_d;
    logic [SLOT_W-1:0]    grant_slot_q, grant_slot_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    logic [SLOT_W-1:0] rr_grant;
    logic              rr_valid;
    logic              rr_adv;
    logic [SLOT_W-1:0] win_slot;
    logic              prio_hit;
    logic              grant_fire;
    logic [CH_W-1:0]   win_ch;
    logic              win_dir;

    rr_arbiter #(
        .REQS (SLOTS)
    ) u_rr (
        .clk_i   (mem_clk),
        .rst_ni  (rst_n),
        .req_i   (eligible),
        .adv_i   (rr_adv),
        .grant_o (rr_grant),
        .valid_o (rr_valid)
    );

`ifdef ARB_CH0_PRIORITY_EN
    always_comb begin
        win_slot = rr_grant;
        prio_hit = 1'b0;
        if (eligible[0]) begin
            win_slot = '0;
            prio_hit = 1'b1;
        end else if (eligible[1]) begin
            win_slot = SLOT_W'(1);
            prio_hit = 1'b1;
        end
    end
`else
    assign win_slot = rr_grant;
    assign prio_hit = 1'b0;
`endif

    // Priority grants leave the round-robin pointer where it was.
    assign grant_fire = (state_q == ST_IDLE) && mem_init_done && rr_valid;
    assign rr_adv     = grant_fire && !prio_hit;
    assign win_ch     = win_slot[SLOT_W-1:1];
    assign win_dir    = win_slot[0];

    always_comb begin
        state_d      = state_q;
        grant_slot_d = grant_slot_q;
        len_d        = len_q;
        addr_d       = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    grant_slot_d = win_slot;
                    if (win_dir == DIR_WR) begin
                        len_d   = wr_len_a[win_ch];
                        addr_d  = wr_addr_a[win_ch];
                        state_d = ST_BUSY_WR;
                    end else begin
                        len_d   = rd_len_a[win_ch];
                        addr_d  = rd_addr_a[win_ch];
                        state_d = ST_BUSY_RD;
                    end
                end
            end
            ST_BUSY_RD: begin
                if (!mem_init_done) begin
                    state_d = ST_IDLE;
                end else if (rd_burst_finish) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_BUSY_WR: begin
                if (!mem_init_done) begin
                    state_d = ST_IDLE;
                end else if (wr_burst_finish) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_slot_q <= '0;
            len_q        <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_slot_q <= grant_slot_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
        end
    end

    logic [CH_W-1:0] g_ch;
    logic            busy_rd, busy_wr;
    logic            rd_live, wr_live;

    assign g_ch    = grant_slot_q[SLOT_W-1:1];
    assign busy_rd = (state_q == ST_BUSY_RD) && (grant_slot_q[0] == DIR_RD);
    assign busy_wr = (state_q == ST_BUSY_WR) && (grant_slot_q[0] == DIR_WR);
    // Calibration loss aborts silently: request and finish are both masked immediately.
    assign rd_live = busy_rd && mem_init_done;
    assign wr_live = busy_wr && mem_init_done;

    assign rd_burst_req  = rd_live && !rd_burst_finish;
    assign wr_burst_req  = wr_live && !wr_burst_finish;
    assign rd_burst_len  = busy_rd ? len_q  : '0;
    assign rd_burst_addr = busy_rd ? addr_q : '0;
    assign wr_burst_len  = busy_wr ? len_q  : '0;
    assign wr_burst_addr = busy_wr ? addr_q : '0;
    assign wr_burst_data = busy_wr ? wr_data_a[g_ch] : '0;
    assign ch_rd_data    = rd_burst_data;

    always_comb begin
        ch_rd_data_valid       = '0;
        ch_wr_data_req         = '0;
        ch_rd_finish           = '0;
        ch_wr_finish           = '0;
        ch_rd_data_valid[g_ch] = busy_rd && rd_burst_data_valid;
        ch_wr_data_req[g_ch]   = busy_wr && wr_burst_data_req;
        ch_rd_finish[g_ch]     = rd_live && rd_burst_finish;
        ch_wr_finish[g_ch]     = wr_live && wr_burst_finish;
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: a behavioural burst engine and channel models drive the DUT.
module tb_mem_burst_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 64;
    localparam int AW     = 24;
    localparam int LB     = 10;
    localparam int SLOTS  = 2 * NUM_CH;

    logic                 mem_clk = 1'b0;
    logic                 rst_n;
    logic                 mem_init_done;
    logic [NUM_CH-1:0]    ch_rd_req, ch_wr_req;
    logic [NUM_CH*LB-1:0] ch_rd_len, ch_wr_len;
    logic [NUM_CH*AW-1:0] ch_rd_addr, ch_wr_addr;
    logic [NUM_CH*DW-1:0] ch_wr_data;
    logic [DW-1:0]        ch_rd_data;
    logic [NUM_CH-1:0]    ch_rd_data_valid, ch_wr_data_req, ch_rd_finish, ch_wr_finish;
    logic                 rd_burst_req, wr_burst_req;
    logic [LB-1:0]        rd_burst_len, wr_burst_len;
    logic [AW-1:0]        rd_burst_addr, wr_burst_addr;
    logic [DW-1:0]        wr_burst_data;
    logic                 rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish;
    logic [DW-1:0]        rd_burst_data;

    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter #(.NUM_CH(NUM_CH), .MEM_DATA_BITS(DW), .ADDR_BITS(AW)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .mem_init_done(mem_init_done),
        .ch_rd_req(ch_rd_req), .ch_rd_len(ch_rd_len), .ch_rd_addr(ch_rd_addr),
        .ch_wr_req(ch_wr_req), .ch_wr_len(ch_wr_len), .ch_wr_addr(ch_wr_addr),
        .ch_wr_data(ch_wr_data), .ch_rd_data(ch_rd_data),
        .ch_rd_data_valid(ch_rd_data_valid), .ch_wr_data_req(ch_wr_data_req),
        .ch_rd_finish(ch_rd_finish), .ch_wr_finish(ch_wr_finish),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .rd_burst_data(rd_burst_data)
    );

    typedef struct packed {
        logic [2:0]    slot;
        logic [AW-1:0] addr;
        logic [LB-1:0] len;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            s_rem  [SLOTS];
    logic [LB-1:0] s_len  [SLOTS];
    logic [AW-1:0] s_addr [SLOTS];

    int      n_chk = 0, n_pass = 0;
    int      cyc = 0, fin_cyc = 0, start_cyc = 0;
    int      beats_left = 0, beats_seen = 0;
    bit      eng_busy = 0, fin_seen = 0, gap_chk = 0;
    logic    nx_rvalid, nx_wdreq, nx_rfin, nx_wfin, nx_init;
    logic [DW-1:0] nx_rdata;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    function automatic logic [DW-1:0] wdata(input int c);
        return 64'hC0DE_0000_0000_0000 + 64'(c) * 64'h0001_0001;
    endfunction

    task automatic set_slot(input int s, input int len, input int addr, input int n);
        s_len[s]  = LB'(len);
        s_addr[s] = AW'(addr);
        s_rem[s]  = n;
    endtask

    task automatic expect_slot(input int s);
        exp_t e;
        e.slot = 3'(s);
        e.addr = s_addr[s];
        e.len  = s_len[s];
        exp_q.push_back(e);
    endtask

    task automatic apply();
        rd_burst_data_valid = nx_rvalid;
        wr_burst_data_req   = nx_wdreq;
        rd_burst_finish     = nx_rfin;
        wr_burst_finish     = nx_wfin;
        rd_burst_data       = nx_rdata;
        mem_init_done       = nx_init;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rd_req[c]          = s_rem[2*c] > 0;
            ch_wr_req[c]          = s_rem[2*c+1] > 0;
            ch_rd_len[c*LB +: LB] = s_len[2*c];
            ch_wr_len[c*LB +: LB] = s_len[2*c+1];
            ch_rd_addr[c*AW +: AW] = s_addr[2*c];
            ch_wr_addr[c*AW +: AW] = s_addr[2*c+1];
            ch_wr_data[c*DW +: DW] = wdata(c);
        end
    endtask

    // One clock: drive just after posedge, observe and score at negedge, plan the next engine cycle.
    task automatic step();
        logic [NUM_CH-1:0] oh, er, ew;
        logic              any_req;
        @(posedge mem_clk);
        #1;
        apply();
        @(negedge mem_clk);
        cyc++;
        oh = 1;
        oh = oh << cur.slot[2:1];
        if (rd_burst_data_valid) begin
            chk("rd_route", {ch_rd_data_valid, ch_rd_data}, {oh, rd_burst_data});
            if ((ch_rd_data_valid & oh) != 0) beats_seen++;
        end else if (ch_rd_data_valid != 0) chk("rd_valid_idle", ch_rd_data_valid, 0);
        if (wr_burst_data_req) begin
            chk("wr_route", {ch_wr_data_req, wr_burst_data}, {oh, wdata(int'(cur.slot[2:1]))});
            if ((ch_wr_data_req & oh) != 0) beats_seen++;
        end else if (ch_wr_data_req != 0) chk("wr_req_idle", ch_wr_data_req, 0);
        er = rd_burst_finish ? oh : '0;
        ew = wr_burst_finish ? oh : '0;
        if ((er | ew | ch_rd_finish | ch_wr_finish) != 0)
            chk("finish", {ch_rd_finish, ch_wr_finish}, {er, ew});
        any_req = rd_burst_req | wr_burst_req;
        if (rd_burst_finish | wr_burst_finish) begin
            chk("req_mask", any_req, 1'b0);
            chk("beats", beats_seen, int'(cur.len));
            chk("addr_hold", cur.slot[0] ? wr_burst_addr : rd_burst_addr, cur.addr);
            s_rem[cur.slot]--;
            eng_busy = 0;
            fin_seen = 1;
            fin_cyc  = cyc;
        end else if (!eng_busy && any_req) begin
            if (exp_q.size() == 0) begin
                chk("unexp_grant", {wr_burst_req, rd_burst_req, rd_burst_addr, wr_burst_addr}, 0);
            end else begin
                cur = exp_q.pop_front();
                chk("grant", {wr_burst_req, (wr_burst_req ? wr_burst_addr : rd_burst_addr),
                              (wr_burst_req ? wr_burst_len : rd_burst_len)},
                             {cur.slot[0], cur.addr, cur.len});
                if (gap_chk && fin_seen) chk("release_gap", cyc - fin_cyc, 3);
                start_cyc  = cyc;
                eng_busy   = 1;
                beats_left = int'(cur.len);
                beats_seen = 0;
            end
        end
        nx_rvalid = 0; nx_wdreq = 0; nx_rfin = 0; nx_wfin = 0;
        if (eng_busy && nx_init) begin
            if (beats_left > 0) begin
                if (cur.slot[0]) nx_wdreq = 1;
                else begin
                    nx_rvalid = 1;
                    nx_rdata  = {$urandom, $urandom};
                end
                beats_left--;
            end else if (cur.slot[0]) nx_wfin = 1;
            else nx_rfin = 1;
        end
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || eng_busy) && n < budget) begin
            step();
            n++;
        end
        chk("done_in_budget", exp_q.size() + int'(eng_busy), 0);
        repeat (6) step();
    endtask

    task automatic do_reset();
        rst_n = 0;
        for (int s = 0; s < SLOTS; s++) set_slot(s, 0, 0, 0);
        exp_q.delete();
        cur = '0;
        eng_busy = 0; fin_seen = 0; gap_chk = 0; beats_seen = 0; beats_left = 0;
        nx_rvalid = 0; nx_wdreq = 0; nx_rfin = 0; nx_wfin = 0; nx_init = 1;
        nx_rdata = 64'h5A5A_1234_DEAD_BEEF;
        apply();
        repeat (2) @(negedge mem_clk);
        chk("rst_ctl", {ch_rd_data_valid, ch_wr_data_req, ch_rd_finish, ch_wr_finish,
                        rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len}, 0);
        chk("rst_bus", {rd_burst_addr, wr_burst_addr, wr_burst_data}, 0);
        chk("rst_rdata", ch_rd_data, 64'h5A5A_1234_DEAD_BEEF);
        @(posedge mem_clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req_cyc;
        int n;

        // Single read on ch1: latency, routing to ch1 only, one finish.
        do_reset();
        set_slot(2, 8, 'h100, 1);
        expect_slot(2);
        req_cyc = cyc + 1;
        run_done(100);
        chk("grant_latency", start_cyc - req_cyc, 1);

        // All slots busy: strict slot order with wrap, one RELEASE cycle between bursts.
        do_reset();
        for (int s = 0; s < SLOTS; s++) set_slot(s, 2, 'h1000 * (s + 1), (s == 0) ? 2 : 1);
        for (int s = 0; s < SLOTS; s++) expect_slot(s);
        expect_slot(0);
        gap_chk = 1;
        run_done(400);

        // ch2 write in flight, ch0 read arrives meanwhile and follows after RELEASE.
        do_reset();
        set_slot(5, 4, 'h5500, 1);
        expect_slot(5);
        step();
        step();
        set_slot(0, 6, 'h0AA0, 1);
        expect_slot(0);
        gap_chk = 1;
        run_done(200);

        // Zero-length ch3 read is never granted; ch1 write goes through.
        do_reset();
        set_slot(6, 0, 'h6600, 1);
        set_slot(3, 3, 'h3300, 1);
        expect_slot(3);
        run_done(100);
        chk("len0_no_grant", {rd_burst_req, ch_rd_finish}, 0);

        // Calibration lost mid-read: silent abort, then the same slot is regranted.
        do_reset();
        set_slot(2, 8, 'h100, 1);
        expect_slot(2);
        n = 0;
        while (beats_seen < 3 && n < 60) begin
            step();
            n++;
        end
        chk("abort_reached", beats_seen >= 3, 1'b1);
        nx_rvalid = 0; nx_rfin = 0; nx_wdreq = 0; nx_wfin = 0;
        nx_init = 0;
        eng_busy = 0;
        step();
        chk("abort_req", {rd_burst_req, wr_burst_req}, 0);
        chk("abort_fin", {ch_rd_finish, ch_wr_finish}, 0);
        repeat (3) begin
            step();
            chk("init_low_hold", {rd_burst_req, wr_burst_req}, 0);
        end
        expect_slot(2);
        nx_init = 1;
        run_done(100);

        // ch0 read re-requested every burst while ch1..3 also read.
        do_reset();
        set_slot(0, 4, 'h0100, 3);
        set_slot(2, 4, 'h2200, 1);
        set_slot(4, 4, 'h4400, 1);
        set_slot(6, 4, 'h6600, 1);
`ifdef ARB_CH0_PRIORITY_EN
        expect_slot(0); expect_slot(0); expect_slot(0);
        expect_slot(2); expect_slot(4); expect_slot(6);
`else
        expect_slot(0); expect_slot(2); expect_slot(4);
        expect_slot(6); expect_slot(0); expect_slot(0);
`endif
        run_done(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
